// File: rtl/mac_writeback_pkg.sv
// Shared MAC writeback constants.
// Flag bit positions, FIFO depth and canonical NaN.
package mac_writeback_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int NFLAGS = 5;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/mac_writeback_if.sv
// Rounder-to-writeback and writeback-to-retire bundle.
// slave is the writeback block, master the surrounding pipeline.
interface mac_writeback_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_CNT  = 16
);

  logic                        Valid_i;
  logic                        Ready_o;
  logic                        Sign_i;
  logic [PARM_EXP-1:0]         Exp_i;
  logic [PARM_MANT-1:0]        Mant_i;
  logic                        Invalid_i;
  logic                        Overflow_i;
  logic                        Underflow_i;
  logic                        Inexact_i;
  logic                        Valid_o;
  logic                        Ready_i;
  logic [PARM_EXP+PARM_MANT:0] Result_o;
  logic [4:0]                  Flags_o;
  logic [4:0]                  Fflags_o;
  logic                        Fflags_clr_i;
  logic [PARM_CNT-1:0]         Retired_cnt_o;

  modport slave (
    input  Valid_i, Sign_i, Exp_i, Mant_i,
    input  Invalid_i, Overflow_i,
    input  Underflow_i, Inexact_i,
    input  Ready_i, Fflags_clr_i,
    output Ready_o, Valid_o, Result_o,
    output Flags_o, Fflags_o, Retired_cnt_o
  );

  modport master (
    output Valid_i, Sign_i, Exp_i, Mant_i,
    output Invalid_i, Overflow_i,
    output Underflow_i, Inexact_i,
    output Ready_i, Fflags_clr_i,
    input  Ready_o, Valid_o, Result_o,
    input  Flags_o, Fflags_o, Retired_cnt_o
  );

endinterface

// File: rtl/mac_wb_fifo.sv
// Two-entry valid/ready FIFO, no bypass.
// in_ready is registered so it never depends on out_ready.
module mac_wb_fifo
  import mac_writeback_pkg::*;
#(
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign out_valid = occ != 2'd0;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    occ_nxt = occ + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      in_ready <= occ_nxt < FIFO_DEPTH;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage is left unreset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/mac_writeback.sv
// MAC writeback: packs rounded results, buffers them,
// accumulates sticky fflags and counts retirements.
module mac_writeback
  import mac_writeback_pkg::*;
#(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_CNT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  mac_writeback_if.slave  io
);

  localparam int W = PARM_EXP + PARM_MANT + 1;

  localparam logic [W-1:0] NAN = {
    1'b0, {PARM_EXP{1'b1}},
    1'b1, {(PARM_MANT-1){1'b0}}
  };

  logic [W-1:0]        packed_res;
  flags_t              in_flags;
  logic [W+4:0]        head;
  flags_t              head_flags;
  flags_t              fflags;
  logic [PARM_CNT-1:0] cnt;
  logic                pop;

  always_comb begin
    packed_res = {io.Sign_i, io.Exp_i, io.Mant_i};
    if ((&io.Exp_i) && (|io.Mant_i)) packed_res = NAN;
    in_flags          = '0;
    in_flags[FLAG_NV] = io.Invalid_i;
    in_flags[FLAG_OF] = io.Overflow_i;
    in_flags[FLAG_UF] = io.Underflow_i;
    in_flags[FLAG_NX] = io.Inexact_i | io.Overflow_i
                      | io.Underflow_i;
  end

  mac_wb_fifo #(
    .WIDTH (W + 5)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (io.Valid_i),
    .in_ready  (io.Ready_o),
    .in_data   ({in_flags, packed_res}),
    .out_valid (io.Valid_o),
    .out_ready (io.Ready_i),
    .out_data  (head)
  );

  assign head_flags = head[W+4:W];
  assign pop        = io.Valid_o & io.Ready_i;

  // Clear wins first, so a same-cycle pop leaves only its own flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
      cnt    <= '0;
    end else begin
      if (io.Fflags_clr_i)
        fflags <= pop ? head_flags : '0;
      else if (pop)
        fflags <= fflags | head_flags;
      if (pop) cnt <= cnt + PARM_CNT'(1);
    end
  end

  assign io.Result_o      = head[W-1:0];
  assign io.Flags_o       = head_flags;
  assign io.Fflags_o      = fflags;
  assign io.Retired_cnt_o = cnt;

endmodule

// File: tb/tb_mac_writeback.sv
// Self-checking bench for mac_writeback.
// Directed vectors, corner sequences and random traffic vs a queue model.
module tb_mac_writeback;
  import mac_writeback_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
  } ent_t;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        nv, of, uf, nx;
    logic [31:0] x_res;
    logic [4:0]  x_fl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_writeback_if #(8, 23, 16) bus ();

  mac_writeback #(
    .PARM_EXP  (8),
    .PARM_MANT (23),
    .PARM_CNT  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  ent_t        q[$];
  logic [4:0]  m_ff  = '0;
  logic [15:0] m_cnt = '0;
  bit          blk   = 1'b1;

  task automatic chk(string n, logic [63:0] a,
                     logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic ent_t pack(logic s, logic [7:0] e,
      logic [22:0] m, logic nv, logic of,
      logic uf, logic nx);
    ent_t r;
    if (e == 8'hFF && m != 0) r.res = CANON_NAN;
    else r.res = {s, e, m};
    r.fl = {nv, 1'b0, of, uf, nx | of | uf};
    return r;
  endfunction

  task automatic drive(logic v, logic s, logic [7:0] e,
      logic [22:0] m, logic nv, logic of,
      logic uf, logic nx);
    bus.Valid_i     = v;
    bus.Sign_i      = s;
    bus.Exp_i       = e;
    bus.Mant_i      = m;
    bus.Invalid_i   = nv;
    bus.Overflow_i  = of;
    bus.Underflow_i = uf;
    bus.Inexact_i   = nx;
  endtask

  // Compare against the model, then advance model and DUT one cycle.
  task automatic tick();
    ent_t e;
    bit   push, pop;
    chk("valid", bus.Valid_o, q.size() != 0);
    chk("ready", bus.Ready_o, !blk && q.size() < 2);
    chk("fflags", bus.Fflags_o, m_ff);
    chk("retired", bus.Retired_cnt_o, m_cnt);
    if (q.size() != 0) begin
      chk("result", bus.Result_o, q[0].res);
      chk("flags", bus.Flags_o, q[0].fl);
    end
    if (rst) begin
      q.delete();
      m_ff  = '0;
      m_cnt = '0;
      blk   = 1'b1;
    end else begin
      push = bus.Valid_i && !blk && q.size() < 2;
      pop  = q.size() != 0 && bus.Ready_i;
      if (bus.Fflags_clr_i) m_ff = '0;
      if (pop) begin
        e = q.pop_front();
        m_ff  = m_ff | e.fl;
        m_cnt = m_cnt + 16'd1;
      end
      if (push)
        q.push_back(pack(bus.Sign_i, bus.Exp_i,
          bus.Mant_i, bus.Invalid_i, bus.Overflow_i,
          bus.Underflow_i, bus.Inexact_i));
      blk = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  logic [15:0] c0;

  initial begin
    vecs[0] = '{1'b0, 8'h7F, 23'h0, 0, 0, 0, 0,
                32'h3F80_0000, 5'b00000};
    vecs[1] = '{1'b0, 8'hFF, 23'h0, 0, 1, 0, 1,
                32'h7F80_0000, 5'b00101};
    vecs[2] = '{1'b1, 8'hFF, 23'h1, 1, 0, 0, 0,
                32'h7FC0_0000, 5'b10000};
    vecs[3] = '{1'b1, 8'h00, 23'h12345, 0, 0, 1, 0,
                32'h8001_2345, 5'b00011};
    vecs[4] = '{1'b0, 8'hFF, 23'h400000, 0, 0, 0, 1,
                32'h7FC0_0000, 5'b00001};
    vecs[5] = '{1'b1, 8'h80, 23'h7FFFFF, 1, 1, 1, 0,
                32'hC07F_FFFF, 5'b10111};

    rst = 1'b1;
    bus.Ready_i = 1'b0;
    bus.Fflags_clr_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    tick();

    // Directed vectors: push, check head, pop, check sticky flags.
    for (int i = 0; i < 6; i++) begin
      bus.Ready_i = 1'b1;
      bus.Fflags_clr_i = 1'b1;
      drive(1, vecs[i].s, vecs[i].e, vecs[i].m,
            vecs[i].nv, vecs[i].of, vecs[i].uf, vecs[i].nx);
      tick();
      bus.Fflags_clr_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("vec_valid", bus.Valid_o, 1'b1);
      chk("vec_result", bus.Result_o, vecs[i].x_res);
      chk("vec_flags", bus.Flags_o, vecs[i].x_fl);
      tick();
      chk("vec_fflags", bus.Fflags_o, vecs[i].x_fl);
      chk("vec_cnt", bus.Retired_cnt_o, 16'(i + 1));
    end

    // Backpressure: two fill, third held upstream.
    c0 = bus.Retired_cnt_o;
    bus.Ready_i = 1'b0;
    drive(1, 0, 8'h01, 23'h1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 8'h02, 23'h2, 0, 0, 0, 0);
    tick();
    chk("bp_ready", bus.Ready_o, 1'b0);
    drive(1, 0, 8'h03, 23'h3, 0, 0, 0, 0);
    tick();
    chk("bp_head", bus.Result_o, 32'h0080_0001);
    bus.Ready_i = 1'b1;
    tick();
    chk("bp_ready_back", bus.Ready_o, 1'b1);
    chk("bp_order", bus.Result_o, 32'h0100_0002);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && q.size() != 0; i++) tick();
    chk("bp_drained", q.size(), 0);
    chk("bp_cnt", bus.Retired_cnt_o, 16'(c0 + 16'd3));

    // Clear coincident with a pop keeps only popped flags.
    bus.Fflags_clr_i = 1'b1;
    drive(1, 0, 8'h10, 0, 0, 0, 0, 1);
    tick();
    bus.Fflags_clr_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("clr_pre", bus.Fflags_o, 5'b00001);
    bus.Ready_i = 1'b0;
    drive(1, 0, 8'h20, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.Ready_i = 1'b1;
    bus.Fflags_clr_i = 1'b1;
    tick();
    bus.Fflags_clr_i = 1'b0;
    chk("clr_pop", bus.Fflags_o, 5'b10000);

    // Reset at occupancy 2 discards without retiring.
    bus.Ready_i = 1'b0;
    drive(1, 1, 8'h33, 23'h5, 0, 1, 0, 0);
    tick();
    tick();
    chk("rst_full", bus.Ready_o, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", bus.Valid_o, 1'b0);
    chk("rst_ready", bus.Ready_o, 1'b0);
    chk("rst_ff", bus.Fflags_o, 5'b0);
    chk("rst_cnt", bus.Retired_cnt_o, 16'd0);
    tick();
    chk("rst_ready_after", bus.Ready_o, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      bus.Ready_i = ($urandom_range(0, 2) != 0);
      bus.Fflags_clr_i = ($urandom_range(0, 9) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
            ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0));
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    bus.Fflags_clr_i = 1'b0;
    bus.Ready_i = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
